regfile_fault_campaign_ctrl: RTL and testbench
==============================================

// Module: regfile_fault_campaign_ctrl
// PURPOSE
//  Sequencer that runs one fault-injection campaign on the register file: fills every register
//  with an address-tagged pattern, arms the configured fault, reads each register back and
//  counts mismatches. Sits between board controls (switches/keys) and the regfile write, read
//  and fault ports. Replaces static port tie-offs with a repeatable self-checking sweep.
// PARAMETERS
//  NREGS    32            number of regfile entries swept (addr 0..NREGS-1)
//  DW       32            regfile data width
//  AW       5             address width, 2**AW >= NREGS
//  PATTERN  32'hA5A5_A5A5 base write pattern (truncated to DW)
//  R0_ZERO  1             1: entry 0 is hardwired zero; expected read of addr 0 is 0
// PORTS
//  clk              in   1      single clock; all state changes on rising edge
//  rst_n            in   1      asynchronous active-low reset
//  start            in   1      1-cycle pulse; starts a campaign; ignored while busy
//  cfg_fault_en     in   1      fault enable for this campaign, latched at start
//  cfg_fault_type   in   2      fault type, latched at start, passed through uninterpreted
//  cfg_fault_addr   in   AW     target register, latched at start
//  cfg_fault_mask   in   DW     bit mask, latched at start
//  busy             out  1      high from cycle after accepted start until DONE
//  done             out  1      1-cycle pulse on campaign completion
//  pass             out  1      err_count==0 at completion; held until next start
//  err_count        out  AW+1   mismatches in last campaign; saturates at all-ones
//  rf_we            out  1      regfile write enable
//  rf_waddr         out  AW     regfile write address
//  rf_wdata         out  DW     regfile write data
//  rf_raddr         out  AW     regfile read port 1 address
//  rf_rdata         in   DW     regfile read port 1 data
//  rf_fault_enable  out  1      regfile fault enable
//  rf_fault_addr    out  AW     regfile fault address
//  rf_fault_mask    out  DW     regfile fault mask
//  rf_fault_type    out  2      regfile fault type
// BEHAVIOUR
//  - Reset: state IDLE; busy/done/pass/rf_we/rf_fault_enable=0; err_count, all addr/data/mask/type outs=0.
//  - All outputs registered. expected(i) = (R0_ZERO && i==0) ? 0 : PATTERN ^ i (i zero-extended).
//  - FSM IDLE -> WRITE -> READ -> CMP -> (READ | DONE) -> IDLE.
//  - IDLE: start=1 latches cfg_*, clears err_count, idx=0, -> WRITE.
//  - WRITE: one register per cycle: rf_we=1, rf_waddr=idx, rf_wdata=expected(idx) (sent
//    unmodified for idx 0 even when R0_ZERO); idx++; after idx=NREGS-1, rf_we=0, idx=0, -> READ.
//  - READ: rf_raddr=idx; rf_fault_* driven from latched cfg (rf_fault_enable=cfg_fault_en)
//    for READ/CMP only, forced 0 during WRITE/IDLE so the fill is never corrupted. -> CMP.
//  - CMP: sample rf_rdata (covers 0- or 1-cycle read latency); rf_rdata != expected(idx)
//    -> err_count+1 (saturating). idx==NREGS-1 -> DONE, else idx++ -> READ.
//  - DONE: done=1 one cycle, pass=(err_count==0), busy=0, rf_fault_enable=0 -> IDLE.
//  - Latency: start accepted at edge T; done high in cycle T+3*NREGS+1 (NREGS write +
//    2*NREGS read/compare + DONE).
//  - start during busy: ignored, no restart or counter effect. start coincident with DONE: ignored.
//  - cfg_* changes mid-campaign: no effect (latched copy used).
//  - cfg_fault_addr >= NREGS: passed through; no swept register is faulted.
//  - rst_n asserted mid-campaign: immediate return to reset values; partial results discarded.
// CONFIGURATION
//  - REGFILE_CAMPAIGN_LOG_EN defined: extra outputs first_err_addr[AW] and first_err_data[DW]
//    capture idx and rf_rdata of the first mismatch of a campaign; cleared to 0 at start and
//    reset; first_err_valid[1] marks capture.
//  - Undefined: these three ports and their registers do not exist; all else identical.
// TESTING
//  1 start, cfg_fault_en=0, golden regfile -> done at T+97 (defaults), pass=1, err_count=0,
//    32 writes seen with rf_wdata(5)=32'hA5A5_A5A0.
//  2 cfg_fault_en=1, addr=3, mask=32'h1, bit-flip type -> pass=0, err_count=1;
//    with LOG_EN first_err_addr=3, first_err_data=32'hA5A5_A5A7.
//  3 start pulsed repeatedly while busy -> single campaign, one done pulse, counts as test 1.
//  4 rst_n low at cycle 40 of campaign -> all outputs at reset values next sample; fresh
//    start completes normally.
//  5 regfile model mismatching every read -> err_count=32 (no wrap), pass=0.
//  6 fault active during WRITE phase checked never asserted: rf_fault_enable=0 while rf_we=1.

Source files
------------

// File: rtl/regfile_fault_campaign_ctrl.sv
// Fault-injection campaign sequencer: fill regfile, arm fault, read back, count mismatches.
// Optional REGFILE_CAMPAIGN_LOG_EN adds first-mismatch capture outputs.
module regfile_fault_campaign_ctrl #(
    parameter int unsigned NREGS   = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 5,
    parameter logic [31:0] PATTERN = 32'hA5A5_A5A5,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cfg_fault_en,
    input  logic [1:0]    cfg_fault_type,
    input  logic [AW-1:0] cfg_fault_addr,
    input  logic [DW-1:0] cfg_fault_mask,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_count,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [AW-1:0] rf_raddr,
    input  logic [DW-1:0] rf_rdata,
    output logic          rf_fault_enable,
    output logic [AW-1:0] rf_fault_addr,
    output logic [DW-1:0] rf_fault_mask,
    output logic [1:0]    rf_fault_type
`ifdef REGFILE_CAMPAIGN_LOG_EN
    ,
    output logic          first_err_valid,
    output logic [AW-1:0] first_err_addr,
    output logic [DW-1:0] first_err_data
`endif
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, CMP, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
    localparam logic [DW-1:0] PAT  = DW'(PATTERN);

    function automatic logic [DW-1:0] expected(input logic [AW-1:0] i);
        if (R0_ZERO && (i == '0)) return '0;
        return PAT ^ DW'(i);
    endfunction

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          cen_q, cen_d;
    logic [1:0]    ctype_q, ctype_d;
    logic [AW-1:0] caddr_q, caddr_d;
    logic [DW-1:0] cmask_q, cmask_d;
    logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [AW:0]   err_q, err_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          fen_q, fen_d;
    logic [AW-1:0] faddr_q, faddr_d;
    logic [DW-1:0] fmask_q, fmask_d;
    logic [1:0]    ftype_q, ftype_d;
    logic          fev_q, fev_d;
    logic [AW-1:0] fea_q, fea_d;
    logic [DW-1:0] fed_q, fed_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cen_d   = cen_q;
        ctype_d = ctype_q;
        caddr_d = caddr_q;
        cmask_d = cmask_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        raddr_d = raddr_q;
        fen_d   = 1'b0;
        faddr_d = '0;
        fmask_d = '0;
        ftype_d = '0;
        fev_d   = fev_q;
        fea_d   = fea_q;
        fed_d   = fed_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cen_d   = cfg_fault_en;
                    ctype_d = cfg_fault_type;
                    caddr_d = cfg_fault_addr;
                    cmask_d = cfg_fault_mask;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    we_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = expected('0);
                    fev_d   = 1'b0;
                    fea_d   = '0;
                    fed_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    raddr_d = '0;
                    fen_d   = cen_q;
                    faddr_d = caddr_q;
                    fmask_d = cmask_q;
                    ftype_d = ctype_q;
                    state_d = READ;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    we_d    = 1'b1;
                    waddr_d = idx_q + 1'b1;
                    wdata_d = expected(idx_q + 1'b1);
                end
            end
            READ: begin
                fen_d   = cen_q;
                faddr_d = caddr_q;
                fmask_d = cmask_q;
                ftype_d = ctype_q;
                state_d = CMP;
            end
            CMP: begin
                // raddr is held through CMP, so sampling here suits 0- or 1-cycle read latency
                if (rf_rdata != expected(idx_q)) begin
                    if (err_q != '1) err_d = err_q + 1'b1;
                    if (!fev_q) begin
                        fev_d = 1'b1;
                        fea_d = idx_q;
                        fed_d = rf_rdata;
                    end
                end
                if (idx_q == LAST) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_d == '0);
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    raddr_d = idx_q + 1'b1;
                    fen_d   = cen_q;
                    faddr_d = caddr_q;
                    fmask_d = cmask_q;
                    ftype_d = ctype_q;
                    state_d = READ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cen_q   <= 1'b0;
            ctype_q <= '0;
            caddr_q <= '0;
            cmask_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            raddr_q <= '0;
            fen_q   <= 1'b0;
            faddr_q <= '0;
            fmask_q <= '0;
            ftype_q <= '0;
            fev_q   <= 1'b0;
            fea_q   <= '0;
            fed_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cen_q   <= cen_d;
            ctype_q <= ctype_d;
            caddr_q <= caddr_d;
            cmask_q <= cmask_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            raddr_q <= raddr_d;
            fen_q   <= fen_d;
            faddr_q <= faddr_d;
            fmask_q <= fmask_d;
            ftype_q <= ftype_d;
            fev_q   <= fev_d;
            fea_q   <= fea_d;
            fed_q   <= fed_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign rf_we           = we_q;
    assign rf_waddr        = waddr_q;
    assign rf_wdata        = wdata_q;
    assign rf_raddr        = raddr_q;
    assign rf_fault_enable = fen_q;
    assign rf_fault_addr   = faddr_q;
    assign rf_fault_mask   = fmask_q;
    assign rf_fault_type   = ftype_q;

`ifdef REGFILE_CAMPAIGN_LOG_EN
    assign first_err_valid = fev_q;
    assign first_err_addr  = fea_q;
    assign first_err_data  = fed_q;
`else
    logic unused_log;
    assign unused_log = ^{fev_q, fea_q, fed_q};
`endif

endmodule

// File: tb/tb_regfile_fault_campaign_ctrl.sv
// Scoreboard bench for regfile_fault_campaign_ctrl with a behavioural regfile and fault model.
module tb_regfile_fault_campaign_ctrl;

    localparam int          NREGS   = 32;
    localparam int          DW      = 32;
    localparam int          AW      = 5;
    localparam logic [31:0] PATTERN = 32'hA5A5_A5A5;
    localparam int          LAT     = 3 * NREGS + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cfg_fault_en = 1'b0;
    logic [1:0]    cfg_fault_type = '0;
    logic [AW-1:0] cfg_fault_addr = '0;
    logic [DW-1:0] cfg_fault_mask = '0;
    logic          busy, done, pass, rf_we, rf_fault_enable;
    logic [AW:0]   err_count;
    logic [AW-1:0] rf_waddr, rf_raddr, rf_fault_addr;
    logic [DW-1:0] rf_wdata, rf_rdata, rf_fault_mask;
    logic [1:0]    rf_fault_type;
`ifdef REGFILE_CAMPAIGN_LOG_EN
    logic          first_err_valid;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;
`endif

    regfile_fault_campaign_ctrl #(
        .NREGS(NREGS), .DW(DW), .AW(AW), .PATTERN(PATTERN), .R0_ZERO(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_fault_en(cfg_fault_en), .cfg_fault_type(cfg_fault_type),
        .cfg_fault_addr(cfg_fault_addr), .cfg_fault_mask(cfg_fault_mask),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_fault_enable(rf_fault_enable), .rf_fault_addr(rf_fault_addr),
        .rf_fault_mask(rf_fault_mask), .rf_fault_type(rf_fault_type)
`ifdef REGFILE_CAMPAIGN_LOG_EN
        ,
        .first_err_valid(first_err_valid), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data)
`endif
    );

    always #5 clk = ~clk;

    // Regfile model: r0 reads zero, 1-cycle read latency; type 01 flips, type 10 sticks to 1.
    logic [DW-1:0] mem [NREGS];
    logic [DW-1:0] rd_flt;
    logic          corrupt_all = 1'b0;

    always_comb begin
        rd_flt = (rf_raddr == '0) ? '0 : mem[rf_raddr];
        if (rf_fault_enable && (rf_fault_addr == rf_raddr)) begin
            case (rf_fault_type)
                2'b01:   rd_flt = rd_flt ^ rf_fault_mask;
                2'b10:   rd_flt = rd_flt | rf_fault_mask;
                default: rd_flt = rd_flt;
            endcase
        end
        if (corrupt_all) rd_flt = ~rd_flt;
    end

    always_ff @(posedge clk) begin
        if (rf_we && (rf_waddr != '0)) mem[rf_waddr] <= rf_wdata;
        rf_rdata <= rd_flt;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          pass;
        logic [AW:0]   err;
        logic          fv;
        logic [AW-1:0] fa;
        logic [DW-1:0] fd;
    } res_t;

    wr_t  wr_q[$];
    res_t res_q[$];
    int   checks = 0;
    int   errors = 0;
    int   viol = 0;
    int   done_seen = 0;
    int   exp_done = 0;

    logic [91:0] outs;
    assign outs = {busy, done, pass, err_count, rf_we, rf_waddr, rf_wdata, rf_raddr,
                   rf_fault_enable, rf_fault_addr, rf_fault_mask, rf_fault_type};

    function automatic logic [DW-1:0] exp_data(input int i);
        if (i == 0) return '0;
        return PATTERN ^ DW'(i);
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor_step();
        wr_t  w;
        res_t r;
        if (!rst_n) return;
        if (rf_we && rf_fault_enable) viol++;
        if (rf_we) begin
            if (wr_q.size() == 0) check("unexpected_write", wr_q.size(), 1);
            else begin
                w = wr_q.pop_front();
                check("wr_addr", rf_waddr, w.addr);
                if (w.addr != '0) check("wr_data", rf_wdata, w.data);
            end
        end
        if (done) begin
            done_seen++;
            if (res_q.size() == 0) check("unexpected_done", res_q.size(), 1);
            else begin
                r = res_q.pop_front();
                check("res_pass", pass, r.pass);
                check("res_err_count", err_count, r.err);
                check("res_busy_low", busy, 0);
`ifdef REGFILE_CAMPAIGN_LOG_EN
                check("res_first_err_valid", first_err_valid, r.fv);
                check("res_first_err_addr", first_err_addr, r.fa);
                check("res_first_err_data", first_err_data, r.fd);
`endif
            end
        end
    endtask

    task automatic push_writes();
        for (int i = 0; i < NREGS; i++) wr_q.push_back('{AW'(i), exp_data(i)});
    endtask

    task automatic campaign(input string nm, input logic en, input logic [1:0] ty,
                            input logic [AW-1:0] fa, input logic [DW-1:0] fm,
                            input logic corrupt, input logic hammer, input res_t exp);
        int n;
        push_writes();
        res_q.push_back(exp);
        exp_done++;
        corrupt_all = corrupt;
        @(negedge clk);
        cfg_fault_en = en; cfg_fault_type = ty; cfg_fault_addr = fa; cfg_fault_mask = fm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        // Inverted config mid-campaign must have no effect.
        cfg_fault_en = ~en; cfg_fault_type = ~ty; cfg_fault_addr = ~fa; cfg_fault_mask = ~fm;
        check({nm, "_busy"}, busy, 1);
        while (!done && n < 300) begin
            start = hammer && ((n % 7) == 0 || n == 96);
            @(negedge clk);
            n++;
        end
        check({nm, "_latency"}, n, LAT);
        if (hammer) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            check({nm, "_idle_after_done"}, busy, 0);
        end else begin
            repeat (2) @(negedge clk);
        end
        check({nm, "_pass_held"}, pass, exp.pass);
    endtask

    task automatic reset_mid();
        push_writes();
        corrupt_all = 1'b0;
        @(negedge clk);
        cfg_fault_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        check("rst_mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", outs, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        repeat (2) @(negedge clk);
        check("reset_outputs", outs, 0);
`ifdef REGFILE_CAMPAIGN_LOG_EN
        check("reset_log", {first_err_valid, first_err_addr, first_err_data}, 0);
`endif
        rst_n = 1'b1;

        campaign("golden", 1'b0, 2'b01, 5'd3, 32'h1, 1'b0, 1'b0,
                 '{1'b1, 6'd0, 1'b0, 5'd0, 32'h0});
        campaign("flip_a3", 1'b1, 2'b01, 5'd3, 32'h1, 1'b0, 1'b0,
                 '{1'b0, 6'd1, 1'b1, 5'd3, 32'hA5A5_A5A7});
        campaign("stuck_a0", 1'b1, 2'b10, 5'd0, 32'h1, 1'b0, 1'b0,
                 '{1'b0, 6'd1, 1'b1, 5'd0, 32'h0000_0001});
        campaign("flip_a31", 1'b1, 2'b01, 5'd31, 32'h8000_0000, 1'b0, 1'b0,
                 '{1'b0, 6'd1, 1'b1, 5'd31, 32'h25A5_A5BA});
        campaign("hammer", 1'b0, 2'b00, 5'd0, 32'h0, 1'b0, 1'b1,
                 '{1'b1, 6'd0, 1'b0, 5'd0, 32'h0});
        campaign("all_bad", 1'b0, 2'b00, 5'd0, 32'h0, 1'b1, 1'b0,
                 '{1'b0, 6'd32, 1'b1, 5'd0, 32'hFFFF_FFFF});
        reset_mid();
        campaign("after_rst", 1'b0, 2'b00, 5'd0, 32'h0, 1'b0, 1'b0,
                 '{1'b1, 6'd0, 1'b0, 5'd0, 32'h0});

        repeat (3) @(negedge clk);
        check("done_pulses", done_seen, exp_done);
        check("writes_drained", wr_q.size(), 0);
        check("results_drained", res_q.size(), 0);
        check("fault_during_write", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
